// File: rtl/milano_pkg.sv
// Shared types for the instruction fetch path: the {pc, instr} entry carried
// from the instr RAM response to decode, and the default buffer depth.
package milano_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned FETCH_BUF_DEPTH = 4;

endpackage

// File: rtl/fetch_buffer_fifo.sv
// Small synchronous FIFO of fetch entries with flush; storage is reset so the
// head never reads as X. Push while full is accepted only when a pop frees a slot.
module fetch_fifo
    import milano_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_BUF_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: pairs each 1-cycle-latency instr RAM response with its PC and
// queues it for decode; raises a prefetch hold before overflow and flushes on jump.
module fetch_buffer
    import milano_pkg::*;
#(
    parameter int unsigned DEPTH      = FETCH_BUF_DEPTH,
    parameter int unsigned HOLD_LEVEL = DEPTH - 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_enable_i,
    input  logic [31:0] instr_addr_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        jump_flag_i,
    input  logic        instr_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fetch_hold_o,
    output logic        overflow_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_LEVEL);

    logic            r_req_q;
    logic [31:0]     r_pc_q;
    logic            r_overflow;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    fetch_entry_t    w_wr_entry;
    fetch_entry_t    w_head;

    // A response belongs to the PC presented one cycle earlier; a jump kills
    // both the response arriving now and the read issued alongside the jump.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_q    <= 1'b0;
            r_pc_q     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_req_q <= fetch_enable_i & ~jump_flag_i;
            r_pc_q  <= instr_addr_i;
            if (w_push & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_push           = r_req_q & ~jump_flag_i;
    assign w_pop            = instr_valid_o & instr_ready_i;
    assign w_wr_entry.pc    = r_pc_q;
    assign w_wr_entry.instr = instr_rdata_i;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (jump_flag_i),
        .i_data  (w_wr_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign instr_valid_o = ~w_empty;
    assign instr_o       = w_head.instr;
    assign pc_o          = w_head.pc;
    assign fetch_hold_o  = (w_count >= HOLD_CNT);
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a 1-cycle-latency instr RAM model whose
// data is a fixed function of the address, so every {pc, instr} pairing is checkable.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fe;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        jump;
    logic        ready;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        hold;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    fetch_buffer #(
        .DEPTH      (4),
        .HOLD_LEVEL (3)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_enable_i (fe),
        .instr_addr_i   (addr),
        .instr_rdata_i  (rdata),
        .jump_flag_i    (jump),
        .instr_ready_i  (ready),
        .instr_valid_o  (valid),
        .instr_o        (instr),
        .pc_o           (pc),
        .fetch_hold_o   (hold),
        .overflow_o     (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) rdata <= ram_f(addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fe = 1'b0; jump = 1'b0; ready = 1'b0; addr = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b exp 0", hold); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_stream();
        do_reset();
        ready = 1'b1; fe = 1'b1; addr = 32'h80;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_latency got %b exp 0", valid); end
        addr = 32'h84;
        step();
        checks++; if (valid !== 1'b1 || pc !== 32'h80 || instr !== 32'h0080_FF7F) begin
            errors++; $display("FAIL stream_e0 got %b/%h/%h exp 1/00000080/0080ff7f", valid, pc, instr); end
        addr = 32'h88;
        step();
        checks++; if (valid !== 1'b1 || pc !== 32'h84 || instr !== 32'h0084_FF7B) begin
            errors++; $display("FAIL stream_e1 got %b/%h/%h exp 1/00000084/0084ff7b", valid, pc, instr); end
        fe = 1'b0;
        step();
        checks++; if (valid !== 1'b1 || pc !== 32'h88 || instr !== 32'h0088_FF77) begin
            errors++; $display("FAIL stream_e2 got %b/%h/%h exp 1/00000088/0088ff77", valid, pc, instr); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_empty got %b exp 0", valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL stream_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            fe = 1'b1; addr = 32'h80 + 32'(4 * k);
            step();
            checks++; if (hold !== (k >= 3)) begin errors++; $display("FAIL ovf_hold_%0d got %b exp %b", k, hold, (k >= 3)); end
        end
        fe = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before_drop got %b exp 0", ovf); end
        step();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_after_drop got %b exp 1", ovf); end
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (valid !== 1'b1 || pc !== 32'h80 + 32'(4 * k) || instr !== ram_f(32'h80 + 32'(4 * k))) begin
                errors++; $display("FAIL ovf_drain_%0d got %b/%h/%h exp 1/%h", k, valid, pc, instr, 32'h80 + 32'(4 * k)); end
            step();
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", valid); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
        ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        fe = 1'b1; addr = 32'h80; step();
        addr = 32'h84; step();
        addr = 32'h88; step();
        checks++; if (valid !== 1'b1 || pc !== 32'h80) begin errors++; $display("FAIL flush_pre got %b/%h exp 1/00000080", valid, pc); end
        addr = 32'h8C; jump = 1'b1;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", valid); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL flush_hold got %b exp 0", hold); end
        jump = 1'b0; addr = 32'h200;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_inflight got %b exp 0", valid); end
        fe = 1'b0;
        step();
        checks++; if (valid !== 1'b1 || pc !== 32'h200 || instr !== 32'h0200_FDFF) begin
            errors++; $display("FAIL flush_target got %b/%h/%h exp 1/00000200/0200fdff", valid, pc, instr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            fe = 1'b1; addr = 32'h80 + 32'(4 * k);
            step();
        end
        fe = 1'b0; ready = 1'b1;
        step();
        checks++; if (ovf !== 1'b0 || hold !== 1'b1) begin errors++; $display("FAIL b2b_full got ovf %b hold %b exp 0/1", ovf, hold); end
        for (int k = 1; k < 5; k++) begin
            checks++; if (valid !== 1'b1 || pc !== 32'h80 + 32'(4 * k)) begin
                errors++; $display("FAIL b2b_drain_%0d got %b/%h exp 1/%h", k, valid, pc, 32'h80 + 32'(4 * k)); end
            step();
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", valid); end
        fe = 1'b1; addr = 32'h300; step();
        addr = 32'h304; step();
        fe = 1'b0;
        checks++; if (valid !== 1'b1 || pc !== 32'h300) begin errors++; $display("FAIL b2b_one got %b/%h exp 1/00000300", valid, pc); end
        step();
        checks++; if (valid !== 1'b1 || pc !== 32'h304 || instr !== 32'h0304_FCFB) begin
            errors++; $display("FAIL b2b_replace got %b/%h/%h exp 1/00000304/0304fcfb", valid, pc, instr); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_last got %b exp 0", valid); end
        ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        fe = 1'b1; addr = 32'h80; step();
        addr = 32'h84; step();
        addr = 32'h88; step();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %b exp 1", valid); end
        #2;
        rst = 1'b1; fe = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0 || hold !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL areset_now got %b/%h/%h/%b/%b exp all 0", valid, instr, pc, hold, ovf); end
        #1;
        rst = 1'b0;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_drop1 got %b exp 0", valid); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_drop2 got %b exp 0", valid); end
    endtask

    task automatic test_wrap();
        int issued = 0;
        int received = 0;
        int cycles = 0;
        do_reset();
        while (received < 12 && cycles < 200) begin
            ready = 1'($urandom_range(0, 1));
            if (valid && ready) begin
                checks++; if (pc !== 32'h1000 + 32'(4 * received) || instr !== ram_f(32'h1000 + 32'(4 * received))) begin
                    errors++; $display("FAIL wrap_%0d got %h/%h exp %h", received, pc, instr, 32'h1000 + 32'(4 * received)); end
                received++;
            end
            fe = (issued < 12) && !hold;
            addr = 32'h1000 + 32'(4 * issued);
            if (fe) issued++;
            step();
            cycles++;
        end
        fe = 1'b0; ready = 1'b0;
        checks++; if (received != 12) begin errors++; $display("FAIL wrap_count got %0d exp 12", received); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b exp 0", ovf); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b exp 0", valid); end
    endtask

    initial begin
        rst = 1'b1; fe = 1'b0; jump = 1'b0; ready = 1'b0; addr = '0;
        test_reset();
        test_stream();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
